dice_game_n: RTL and testbench
==============================

# dice_game_n

Parametrised dice-game core: NUM_DICE odometer-chained die counters spin while `roll` is held, and freeze on release. The frozen sum is scored by a craps-style state machine with a point phase. The block drives one 7-segment digit per die plus win/lose/point status. It replaces the fixed two-die game core and its separate counters block at the top of the dice design.

## Interface
- NUM_DICE, 2: number of dice, 1..4
- FACES, 6: faces per die, 2..9; die values run 1..FACES
- WIN_A, 7: first-roll natural win; also the point-phase losing sum
- WIN_B, 11: second first-roll natural win
- LOSE_A / LOSE_B / LOSE_C, 2 / 3 / 12: first-roll losing sums
- Derived widths: DW = $clog2(FACES+1); SW = $clog2(NUM_DICE*FACES+1)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- roll  in  1  level; high = dice spinning; synchronous, debounced upstream
- new_game  in  1  single-cycle pulse; starts a new game
- dice_out  out  NUM_DICE*DW  die k at bits [k*DW +: DW]
- sum_out  out  SW  sum of all current die values
- segdisp  out  NUM_DICE*7  digit k at [k*7 +: 7]; bit0=a … bit6=g; active-high
- point  out  SW  established point; 0 when no point
- win  out  1  registered; high while in WIN
- lose  out  1  registered; high while in LOSE
- roll_count  out  8  scored rolls in this game, saturates at 255

## Operation
- States: IDLE, COME_OUT, POINT_WAIT, POINT_ROLL, WIN, LOSE.
- Reset values:
  - all dice = 1; sum_out = NUM_DICE; segdisp shows "1" on every digit
  - point = 0; win = 0; lose = 0; roll_count = 0
  - state = IDLE; roll_q = 0
- Counters:
  - On every clk edge with roll=1 in IDLE, COME_OUT, POINT_WAIT or POINT_ROLL, die 0 advances.
  - Die k>0 advances on the same edge that die k-1 wraps FACES→1 (odometer).
  - Die value FACES wraps to 1.
  - Dice hold their values in all other cases.
- Roll start transitions:
  - IDLE with roll=1 → COME_OUT.
  - POINT_WAIT with roll=1 → POINT_ROLL.
- Release is the edge where roll=0 and roll_q=1. On release, the current sum S is scored and roll_count increments.
- Scoring in COME_OUT:
  - S ∈ {WIN_A, WIN_B} → WIN.
  - S ∈ {LOSE_A, LOSE_B, LOSE_C} → LOSE.
  - Otherwise point ← S and state → POINT_WAIT.
- Scoring in POINT_ROLL:
  - S == point → WIN.
  - S == WIN_A → LOSE.
  - Otherwise → POINT_WAIT.
- WIN and LOSE are terminal. roll is ignored and dice freeze. Only new_game or reset leaves these states.
- new_game:
  - From any state → IDLE; point = 0; roll_count = 0; win = lose = 0.
  - Dice keep their values.
  - Takes priority over a release on the same edge. That release is discarded.
- Reset asserted mid-roll: everything returns to reset values immediately (asynchronous). On deassertion the block starts in IDLE; roll_q = 0, so no spurious release is detected.
- Arithmetic: sum_out is an unsigned SW-bit sum and never overflows by construction. Compare widths match SW.

## Timing
- dice_out, sum_out and segdisp change one cycle after each counting edge. sum_out and segdisp are combinational from the die registers.
- win, lose, point and roll_count update on the release edge, one clock after roll is first sampled low.
- Minimum roll pulse is one clock, which gives one advance.
- A roll=1 in POINT_WAIT on the edge directly following the release is accepted.

## Structure
- Package dice_pkg holds:
  - the state enum typedef
  - default rule constants (WIN_A/B, LOSE_A/B/C)
  - the 7-segment pattern constants for digits 0..9
- Sub-module dice_seg7: combinational value→segment decoder, instantiated NUM_DICE times via generate.
- The counter chain, FSM and roll edge detector live in dice_game_n.

## Test plan
Defaults throughout: NUM_DICE=2, FACES=6.
- Reset: assert rst=0 mid-roll → dice (1,1), sum 2, win=lose=0, point=0, segdisp shows "1","1".
- Natural win: from reset, roll high for 5 cycles then low → dice (6,1), sum 7, win=1 one cycle after release, roll_count=1.
- Craps loss: from reset, roll high for 1 cycle → dice (2,1), sum 3, lose=1.
- Point then loss on 7: roll for 2 cycles → (3,1), point=4, POINT_WAIT. Roll for 3 cycles → (6,1), sum 7 → lose=1, roll_count=2.
- Point then win: roll for 2 cycles → point=4. Roll for 6 cycles → (3,2), sum 5, stays POINT_WAIT. Roll for 30 more cycles → (3,1), sum 4 → win=1, roll_count=3.
- Terminal/new_game: in WIN, roll for 4 cycles → dice unchanged. new_game pulse coincident with a release → IDLE, point=0, roll_count=0, no scoring.

Source files
------------

// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared types, default craps rules and 7-segment patterns for the dice game
package dice_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COME_OUT,
    ST_POINT_WAIT,
    ST_POINT_ROLL,
    ST_WIN,
    ST_LOSE
  } state_t;

  // Default craps rule sums
  localparam int DEF_WIN_A  = 7;
  localparam int DEF_WIN_B  = 11;
  localparam int DEF_LOSE_A = 2;
  localparam int DEF_LOSE_B = 3;
  localparam int DEF_LOSE_C = 12;

  // Active-high segment patterns, bit0=a ... bit6=g
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

endpackage

// File: rtl/dice_seg7.sv
// rtl/dice_seg7.sv - combinational die value to 7-segment decoder
module dice_seg7
  import dice_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] value,
  output logic [6:0]   seg
);

  logic [3:0] v4;

  assign v4 = 4'(value);

  // Map a digit to its segment pattern; out-of-range values blank the digit
  always_comb begin
    seg = 7'h00;
    case (v4)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/dice_game_n.sv
// rtl/dice_game_n.sv - odometer-chained dice counters with a craps scoring state machine
module dice_game_n
  import dice_pkg::*;
#(
  parameter int NUM_DICE = 2,
  parameter int FACES    = 6,
  parameter int WIN_A    = DEF_WIN_A,
  parameter int WIN_B    = DEF_WIN_B,
  parameter int LOSE_A   = DEF_LOSE_A,
  parameter int LOSE_B   = DEF_LOSE_B,
  parameter int LOSE_C   = DEF_LOSE_C,
  localparam int DW      = $clog2(FACES + 1),
  localparam int SW      = $clog2(NUM_DICE * FACES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   roll,
  input  logic                   new_game,
  output logic [NUM_DICE*DW-1:0] dice_out,
  output logic [SW-1:0]          sum_out,
  output logic [NUM_DICE*7-1:0]  segdisp,
  output logic [SW-1:0]          point,
  output logic                   win,
  output logic                   lose,
  output logic [7:0]             roll_count
);

  localparam int MAX_SUM = NUM_DICE * FACES;
  localparam logic [DW-1:0] FACES_V = DW'(FACES);
  localparam logic [DW-1:0] ONE_V   = DW'(1);

  // Rule sums that cannot be reached by this many dice never match
  // (avoids a truncated constant aliasing onto a reachable sum)
  localparam bit WIN_A_OK  = (WIN_A  <= MAX_SUM);
  localparam bit WIN_B_OK  = (WIN_B  <= MAX_SUM);
  localparam bit LOSE_A_OK = (LOSE_A <= MAX_SUM);
  localparam bit LOSE_B_OK = (LOSE_B <= MAX_SUM);
  localparam bit LOSE_C_OK = (LOSE_C <= MAX_SUM);
  localparam logic [SW-1:0] WIN_A_S  = SW'(WIN_A);
  localparam logic [SW-1:0] WIN_B_S  = SW'(WIN_B);
  localparam logic [SW-1:0] LOSE_A_S = SW'(LOSE_A);
  localparam logic [SW-1:0] LOSE_B_S = SW'(LOSE_B);
  localparam logic [SW-1:0] LOSE_C_S = SW'(LOSE_C);

  state_t              state, state_d;
  logic [DW-1:0]       die_q [NUM_DICE];
  logic [NUM_DICE-1:0] adv;
  logic                roll_q;
  logic                release_evt;
  logic                count_en;
  logic [SW-1:0]       point_d;
  logic [7:0]          roll_count_d;
  logic [7:0]          roll_count_inc;
  logic                hit_win_a, hit_natural, hit_craps;

  assign release_evt    = roll_q & ~roll;
  assign count_en       = roll & (state inside {ST_IDLE, ST_COME_OUT, ST_POINT_WAIT, ST_POINT_ROLL});
  assign roll_count_inc = (roll_count == 8'hFF) ? 8'hFF : roll_count + 8'd1;

  assign hit_win_a   = WIN_A_OK && (sum_out == WIN_A_S);
  assign hit_natural = hit_win_a || (WIN_B_OK && (sum_out == WIN_B_S));
  assign hit_craps   = (LOSE_A_OK && (sum_out == LOSE_A_S)) ||
                       (LOSE_B_OK && (sum_out == LOSE_B_S)) ||
                       (LOSE_C_OK && (sum_out == LOSE_C_S));

  // Odometer carry chain: die k steps when every lower die steps and wraps
  always_comb begin
    adv    = '0;
    adv[0] = count_en;
    for (int k = 1; k < NUM_DICE; k++) begin
      adv[k] = adv[k-1] && (die_q[k-1] == FACES_V);
    end
  end

  // Die registers: step 1..FACES with wrap back to 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_DICE; k++) die_q[k] <= ONE_V;
    end else begin
      for (int k = 0; k < NUM_DICE; k++) begin
        if (adv[k]) die_q[k] <= (die_q[k] == FACES_V) ? ONE_V : die_q[k] + ONE_V;
      end
    end
  end

  // Sum of all dice, combinational from the die registers
  always_comb begin
    sum_out = '0;
    for (int k = 0; k < NUM_DICE; k++) sum_out = sum_out + SW'(die_q[k]);
  end

  // Per-die bus packing and digit decoders
  for (genvar g = 0; g < NUM_DICE; g++) begin : g_die
    assign dice_out[g*DW +: DW] = die_q[g];
    dice_seg7 #(.W(DW)) u_seg (
      .value (die_q[g]),
      .seg   (segdisp[g*7 +: 7])
    );
  end

  // Game state, scoring results and roll edge history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      roll_q     <= 1'b0;
      point      <= '0;
      roll_count <= 8'd0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else begin
      state      <= state_d;
      roll_q     <= roll;
      point      <= point_d;
      roll_count <= roll_count_d;
      win        <= (state_d == ST_WIN);
      lose       <= (state_d == ST_LOSE);
    end
  end

  // Next state and scoring; new_game overrides any release on the same edge
  always_comb begin
    state_d      = state;
    point_d      = point;
    roll_count_d = roll_count;
    if (new_game) begin
      state_d      = ST_IDLE;
      point_d      = '0;
      roll_count_d = 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (roll) state_d = ST_COME_OUT;
        end
        ST_COME_OUT: begin
          if (release_evt) begin
            roll_count_d = roll_count_inc;
            if (hit_natural) begin
              state_d = ST_WIN;
            end else if (hit_craps) begin
              state_d = ST_LOSE;
            end else begin
              point_d = sum_out;
              state_d = ST_POINT_WAIT;
            end
          end
        end
        ST_POINT_WAIT: begin
          if (roll) state_d = ST_POINT_ROLL;
        end
        ST_POINT_ROLL: begin
          if (release_evt) begin
            roll_count_d = roll_count_inc;
            if (sum_out == point)  state_d = ST_WIN;
            else if (hit_win_a)    state_d = ST_LOSE;
            else                   state_d = ST_POINT_WAIT;
          end
        end
        default: state_d = state;
      endcase
    end
  end

endmodule

// File: tb/tb_dice_game_n.sv
// tb/tb_dice_game_n.sv - scoreboard testbench for dice_game_n with default parameters
module tb_dice_game_n;

  logic        clk;
  logic        rst;
  logic        roll;
  logic        new_game;
  logic [5:0]  dice_out;
  logic [3:0]  sum_out;
  logic [13:0] segdisp;
  logic [3:0]  point;
  logic        win;
  logic        lose;
  logic [7:0]  roll_count;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    int d0, d1, sum, pt, w, l, cnt;
  } exp_t;

  exp_t exp_q[$];

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  dice_game_n dut (
    .clk        (clk),
    .rst        (rst),
    .roll       (roll),
    .new_game   (new_game),
    .dice_out   (dice_out),
    .sum_out    (sum_out),
    .segdisp    (segdisp),
    .point      (point),
    .win        (win),
    .lose       (lose),
    .roll_count (roll_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int d0, d1, sum, pt, w, l, cnt);
    exp_t e;
    e.d0 = d0; e.d1 = d1; e.sum = sum; e.pt = pt; e.w = w; e.l = l; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic check_out(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val({name, ".queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_val({name, ".die0"},  dice_out[2:0], e.d0);
      check_val({name, ".die1"},  dice_out[5:3], e.d1);
      check_val({name, ".sum"},   sum_out, e.sum);
      check_val({name, ".seg"},   segdisp, {seg_tab[e.d1], seg_tab[e.d0]});
      check_val({name, ".point"}, point, e.pt);
      check_val({name, ".win"},   win, e.w);
      check_val({name, ".lose"},  lose, e.l);
      check_val({name, ".count"}, roll_count, e.cnt);
    end
  endtask

  task automatic do_reset();
    roll     = 1'b0;
    new_game = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Hold roll for n edges, then release; returns at the negedge after the release edge
  task automatic roll_for(input int n);
    roll = 1'b1;
    repeat (n) @(negedge clk);
    roll = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    roll     = 1'b0;
    new_game = 1'b0;
    #1;
    do_reset();
    push_exp(1, 1, 2, 0, 0, 0, 0);
    check_out("reset");

    // Reset asserted in the middle of a roll
    roll = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    push_exp(1, 1, 2, 0, 0, 0, 0);
    check_out("rst_mid_roll");
    roll = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_exp(1, 1, 2, 0, 0, 0, 0);
    check_out("rst_release");

    // Natural win on 7
    roll_for(5);
    push_exp(6, 1, 7, 0, 1, 0, 1);
    check_out("nat_win");

    // new_game from WIN keeps dice, clears results
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    push_exp(6, 1, 7, 0, 0, 0, 0);
    check_out("new_game_win");

    // Craps loss on 3
    do_reset();
    roll_for(1);
    push_exp(2, 1, 3, 0, 0, 1, 1);
    check_out("craps");

    // Point 4 then 7 loses; second roll starts right after the release
    do_reset();
    roll_for(2);
    push_exp(3, 1, 4, 4, 0, 0, 1);
    check_out("point4_set");
    roll_for(3);
    push_exp(6, 1, 7, 4, 0, 1, 2);
    check_out("seven_out");

    // Point 4, miss on 5, then make the point
    do_reset();
    roll_for(2);
    push_exp(3, 1, 4, 4, 0, 0, 1);
    check_out("point4_again");
    roll_for(6);
    push_exp(3, 2, 5, 4, 0, 0, 2);
    check_out("miss5");
    roll_for(30);
    push_exp(3, 1, 4, 4, 1, 0, 3);
    check_out("make_point");

    // Terminal WIN ignores roll; new_game on the release edge discards the score
    roll = 1'b1;
    repeat (4) @(negedge clk);
    push_exp(3, 1, 4, 4, 1, 0, 3);
    check_out("win_frozen");
    roll     = 1'b0;
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    push_exp(3, 1, 4, 0, 0, 0, 0);
    check_out("new_game_release");
    @(negedge clk);
    push_exp(3, 1, 4, 0, 0, 0, 0);
    check_out("idle_hold");

    // A fresh game after new_game scores normally
    roll_for(1);
    push_exp(4, 1, 5, 5, 0, 0, 1);
    check_out("fresh_game");

    if (exp_q.size() != 0) check_val("queue_leftover", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
